if_id_skid: RTL and testbench
=============================

IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 SHALL have parameter: N, 32, datapath width of PC and instruction fields.
REQ-002 SHALL have port: clk  in  1  single clock, rising-edge active.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: flush  in  1  synchronous squash of all buffered entries (branch/jump taken).
REQ-005 SHALL have port: in_valid  in  1  fetch presents an entry.
REQ-006 SHALL have port: in_ready  out  1  buffer can accept an entry this cycle.
REQ-007 SHALL have port: in_pc  in  N  PC of fetched instruction.
REQ-008 SHALL have port: in_inst  in  N  fetched instruction word.
REQ-009 SHALL have port: out_valid  out  1  decode-side entry valid.
REQ-010 SHALL have port: out_ready  in  1  decode accepts the entry (low means stall).
REQ-011 SHALL have port: out_pc  out  N  PC of head entry.
REQ-012 SHALL have port: out_inst  out  N  instruction of head entry.
REQ-013 SHALL have port: count  out  2  number of buffered entries (0..2).

Function
REQ-014 SHALL implement a 2-entry skid buffer: a main entry driving the outputs and a skid entry, both registered.
REQ-015 SHALL use states EMPTY (count 0), ONE (main only), TWO (main + skid).
REQ-016 SHALL accept input when in_valid and in_ready are both high, and SHALL release output when out_valid and out_ready are both high.
REQ-017 SHALL drive in_ready as a registered signal equal to (state != TWO), with no combinational path from out_ready.
REQ-018 SHALL drive out_valid high exactly in states ONE and TWO.
REQ-019 SHALL give one-cycle latency: an entry accepted into EMPTY at edge t appears on out_* after edge t.
REQ-020 SHALL preserve FIFO order; the skid entry moves into main on the edge where main is released.
REQ-021 SHALL perform these transitions: EMPTY + accept -> ONE.
REQ-022 SHALL perform: ONE + accept + release -> ONE, with main loaded from input.
REQ-023 SHALL perform: ONE + accept with no release -> TWO, with skid loaded.
REQ-024 SHALL perform: ONE + release with no accept -> EMPTY.
REQ-025 SHALL perform: TWO + release -> ONE, with main loaded from skid; no accept is possible in TWO.
REQ-026 SHALL give flush priority over all other events: at the next edge state -> EMPTY, any input presented in the same cycle is discarded, and count -> 0.
REQ-027 SHALL drive out_inst to NOP 0x00000013 and out_pc to 0 whenever out_valid is low.
REQ-028 SHALL hold out_pc and out_inst stable while out_valid is high and out_ready is low.
REQ-029 SHALL treat in_pc and in_inst as don't-care when in_valid is low, and SHALL never load them.

Reset
REQ-030 SHALL, on rst assertion, immediately and asynchronously force state EMPTY, out_valid 0, in_ready 1, count 0, out_pc 0, out_inst NOP.
REQ-031 SHALL reset all internal data registers to 0.
REQ-032 SHALL, when rst is asserted mid-operation, lose all buffered entries with no partial transfer.
REQ-033 SHALL allow acceptance on the first rising edge after rst deasserts.

Structure
REQ-034 SHALL place the NOP constant (0x00000013) and the state encoding (EMPTY/ONE/TWO, 2 bits) in a shared package (riscv_pkg).
REQ-035 SHALL implement each entry as an instance of one sub-module, skid_entry, which stores {pc, inst} with a load enable and async active-high reset.
REQ-036 SHALL keep all next-state and load-enable logic in the top module.

Verification
REQ-037 SHALL cover streaming: out_ready=1; in_pc 0x0, 0x4, 0x8 on consecutive cycles -> out_pc 0x0, 0x4, 0x8 one cycle later each; count stays 1; in_ready stays 1.
REQ-038 SHALL cover stall fill: out_ready=0; accept 0x10 then 0x14 -> count 2 and in_ready 0; out_pc holds 0x10; a third offer (0x18) is not accepted.
REQ-039 SHALL cover drain: from the REQ-038 state, raise out_ready -> out_pc 0x10 then 0x14, count 2->1->0, in_ready returns to 1 after the first release.
REQ-040 SHALL cover flush with concurrent input: state TWO, flush=1 and in_valid=1 (0x20) in the same cycle -> next cycle out_valid 0, out_inst 0x00000013, count 0, and 0x20 never appears.
REQ-041 SHALL cover async reset mid-cycle: state TWO, pulse rst between edges -> outputs reach reset values before the next edge; the accept on the first edge after release shows the new pc.
REQ-042 SHALL include an ordering/no-loss check under random in_valid/out_ready (10k cycles) with a scoreboard -> zero drops, zero duplicates.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and state encoding for the IF/ID pipeline skid buffer.
// The decode side sees NOP whenever no real entry is present.
package riscv_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // Occupancy is fully determined by the state, so count is derived rather than stored.
    function automatic logic [1:0] state_count(input skid_state_t s);
        logic [1:0] c;
        c = 2'd0;
        case (s)
            EMPTY:   c = 2'd0;
            ONE:     c = 2'd1;
            TWO:     c = 2'd2;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/skid_entry.sv
// One buffered IF/ID slot: a registered {pc, inst} pair with a load enable.
module skid_entry #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [N-1:0] i_pc,
    input  logic [N-1:0] i_inst,
    output logic [N-1:0] o_pc,
    output logic [N-1:0] o_inst
);

    logic [N-1:0] r_pc;
    logic [N-1:0] r_inst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc   <= '0;
            r_inst <= '0;
        end else if (i_load) begin
            r_pc   <= i_pc;
            r_inst <= i_inst;
        end
    end

    assign o_pc   = r_pc;
    assign o_inst = r_inst;

endmodule

// File: rtl/if_id_skid.sv
// Two-entry skid buffer between fetch and decode. The main entry drives decode;
// the skid entry absorbs one extra fetch when decode stalls.
module if_id_skid
    import riscv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_pc,
    input  logic [N-1:0] in_inst,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_pc,
    output logic [N-1:0] out_inst,
    output logic [1:0]   count
);

    skid_state_t  r_state;
    skid_state_t  w_next_state;
    logic         r_in_ready;

    logic         w_accept;
    logic         w_release;
    logic         w_load_main;
    logic         w_load_skid;
    logic         w_main_from_skid;

    logic [N-1:0] w_main_pc_d;
    logic [N-1:0] w_main_inst_d;
    logic [N-1:0] w_main_pc;
    logic [N-1:0] w_main_inst;
    logic [N-1:0] w_skid_pc;
    logic [N-1:0] w_skid_inst;

    assign w_accept  = in_valid & r_in_ready;
    assign w_release = out_valid & out_ready;

    // in_ready is registered from the next state so out_ready never reaches fetch combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != TWO);
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_next_state = ONE;
                        w_load_main  = 1'b1;
                    end
                end
                ONE: begin
                    case ({w_accept, w_release})
                        2'b11: begin
                            w_next_state = ONE;
                            w_load_main  = 1'b1;
                        end
                        2'b10: begin
                            w_next_state = TWO;
                            w_load_skid  = 1'b1;
                        end
                        2'b01: begin
                            w_next_state = EMPTY;
                        end
                        default: begin
                            w_next_state = ONE;
                        end
                    endcase
                end
                TWO: begin
                    if (w_release) begin
                        w_next_state     = ONE;
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_next_state = EMPTY;
                end
            endcase
        end
    end

    // Main refills from skid on a release in TWO to keep FIFO order.
    assign w_main_pc_d   = w_main_from_skid ? w_skid_pc   : in_pc;
    assign w_main_inst_d = w_main_from_skid ? w_skid_inst : in_inst;

    skid_entry #(.N(N)) u_main (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_main),
        .i_pc   (w_main_pc_d),
        .i_inst (w_main_inst_d),
        .o_pc   (w_main_pc),
        .o_inst (w_main_inst)
    );

    skid_entry #(.N(N)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_skid),
        .i_pc   (in_pc),
        .i_inst (in_inst),
        .o_pc   (w_skid_pc),
        .o_inst (w_skid_inst)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != EMPTY);
    assign out_pc    = out_valid ? w_main_pc   : '0;
    assign out_inst  = out_valid ? w_main_inst : N'(NOP);
    assign count     = state_count(r_state);

endmodule

// File: tb/tb_if_id_skid.sv
// Directed and randomized checks of the IF/ID skid buffer against hand-computed
// values and a queue model of the expected entry order.
module tb_if_id_skid;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [1:0]  count;

    int vectorsApplied = 0;
    int miscompares    = 0;

    if_id_skid #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic stepClock;
        @(posedge clk);
        #1;
    endtask

    // Observed/expected packed as {out_valid, in_ready, count, out_pc, out_inst}.
    task automatic checkOutput(input string tag, input logic ev, input logic er, input logic [1:0] ec,
                               input logic [31:0] ep, input logic [31:0] ei);
        logic [67:0] obs;
        logic [67:0] exp;
        obs = {out_valid, in_ready, count, out_pc, out_inst};
        exp = {ev, er, ec, ep, ei};
        vectorsApplied++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] sbQ[$];
        logic [31:0] nextPc;
        logic [31:0] headPc;
        logic        rv;
        logic        rr;
        logic        acc;
        logic        rel;

        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        checkOutput("reset", 1'b0, 1'b1, 2'd0, 32'h0, NOP);
        stepClock();
        stepClock();
        rst = 1'b0;

        applyStimulus(1'b1, 32'h0, 32'hA0, 1'b1, 1'b0);
        stepClock();
        checkOutput("stream0", 1'b1, 1'b1, 2'd1, 32'h0, 32'hA0);
        applyStimulus(1'b1, 32'h4, 32'hA4, 1'b1, 1'b0);
        stepClock();
        checkOutput("stream4", 1'b1, 1'b1, 2'd1, 32'h4, 32'hA4);
        applyStimulus(1'b1, 32'h8, 32'hA8, 1'b1, 1'b0);
        stepClock();
        checkOutput("stream8", 1'b1, 1'b1, 2'd1, 32'h8, 32'hA8);
        applyStimulus(1'b0, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
        stepClock();
        checkOutput("stream_end", 1'b0, 1'b1, 2'd0, 32'h0, NOP);

        applyStimulus(1'b1, 32'h10, 32'hB10, 1'b0, 1'b0);
        stepClock();
        checkOutput("fill1", 1'b1, 1'b1, 2'd1, 32'h10, 32'hB10);
        applyStimulus(1'b1, 32'h14, 32'hB14, 1'b0, 1'b0);
        stepClock();
        checkOutput("fill2", 1'b1, 1'b0, 2'd2, 32'h10, 32'hB10);
        applyStimulus(1'b1, 32'h18, 32'hB18, 1'b0, 1'b0);
        stepClock();
        checkOutput("fill_refused", 1'b1, 1'b0, 2'd2, 32'h10, 32'hB10);

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        stepClock();
        checkOutput("drain1", 1'b1, 1'b1, 2'd1, 32'h14, 32'hB14);
        stepClock();
        checkOutput("drain2", 1'b0, 1'b1, 2'd0, 32'h0, NOP);

        applyStimulus(1'b1, 32'h30, 32'hC30, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b1, 32'h34, 32'hC34, 1'b0, 1'b0);
        stepClock();
        checkOutput("preflush", 1'b1, 1'b0, 2'd2, 32'h30, 32'hC30);
        applyStimulus(1'b1, 32'h20, 32'hC20, 1'b0, 1'b1);
        stepClock();
        checkOutput("flush", 1'b0, 1'b1, 2'd0, 32'h0, NOP);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        stepClock();
        checkOutput("postflush", 1'b0, 1'b1, 2'd0, 32'h0, NOP);

        applyStimulus(1'b1, 32'h40, 32'hD40, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b1, 32'h44, 32'hD44, 1'b0, 1'b0);
        stepClock();
        checkOutput("prereset", 1'b1, 1'b0, 2'd2, 32'h40, 32'hD40);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 1'b0, 1'b1, 2'd0, 32'h0, NOP);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 32'h50, 32'hD50, 1'b0, 1'b0);
        stepClock();
        checkOutput("after_reset", 1'b1, 1'b1, 2'd1, 32'h50, 32'hD50);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        stepClock();
        checkOutput("after_reset_drain", 1'b0, 1'b1, 2'd0, 32'h0, NOP);

        // Random handshakes; inst is ~pc so both fields are checked against the queue head.
        nextPc = 32'h1000;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rv = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            if (rv)
                applyStimulus(1'b1, nextPc, ~nextPc, rr, 1'b0);
            else
                applyStimulus(1'b0, $urandom, $urandom, rr, 1'b0);
            if (sbQ.size() != 0) begin
                headPc = sbQ[0];
                checkOutput("random", 1'b1, (sbQ.size() != 2), 2'(sbQ.size()), headPc, ~headPc);
            end else begin
                checkOutput("random", 1'b0, 1'b1, 2'd0, 32'h0, NOP);
            end
            acc = rv && (sbQ.size() < 2);
            rel = rr && (sbQ.size() > 0);
            stepClock();
            if (rel)
                void'(sbQ.pop_front());
            if (acc) begin
                sbQ.push_back(nextPc);
                nextPc = nextPc + 32'd4;
            end
        end

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        while (sbQ.size() != 0) begin
            headPc = sbQ[0];
            checkOutput("random_drain", 1'b1, (sbQ.size() != 2), 2'(sbQ.size()), headPc, ~headPc);
            stepClock();
            void'(sbQ.pop_front());
        end
        checkOutput("random_empty", 1'b0, 1'b1, 2'd0, 32'h0, NOP);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
